// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// State encoding, default header base and one-hot decode.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_t;

    localparam logic [7:0] HDR_BASE_DEF = 8'hA0;

    // Index of the set bit of a one-hot vector of up to 8 bits.
    function automatic logic [2:0] onehot_to_idx(
        input logic [7:0] oh
    );
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                r = r | 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
// Searches upward from ptr+1 with wrap-around.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             found
);

    int            pos;
    logic [IW-1:0] sel;
    logic [7:0]    g8;

    // First requester after the last winner takes the grant.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = 0;
        sel   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            sel = pos[IW-1:0];
            if (!found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
            end
        end
    end

    // Widen the grant so the shared decoder can turn it into an index.
    always_comb begin
        g8             = '0;
        g8[N_REQ-1:0]  = gnt;
        idx            = IW'(onehot_to_idx(g8));
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin arbiter for one UART TX byte port.
// Optional per-message source header, length cap and stall watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DI_WIDTH = 8,
    parameter int HDR_EN = 1,
    parameter logic [DI_WIDTH-1:0] HDR_BASE = DI_WIDTH'(HDR_BASE_DEF),
    parameter int MAX_LEN = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ*DI_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]          req_vld,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_rdy,
    output logic [DI_WIDTH-1:0]       tx_din,
    output logic                      tx_din_vld,
    input  logic                      tx_rfd,
    output logic [N_REQ-1:0]          gnt,
    output logic                      busy,
    output logic                      abort,
    output logic                      trunc
);

    localparam int IW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_LEN + 1);
    localparam int SW = $clog2(TIMEOUT + 1);

    state_t              state;
    logic [IW-1:0]       ptr;
    logic [BW-1:0]       byte_cnt;
    logic [SW-1:0]       stall_cnt;

    logic [N_REQ-1:0]    pick_gnt;
    logic [IW-1:0]       pick_idx;
    logic                pick_found;

    logic [DI_WIDTH-1:0] lane [N_REQ];
    logic [DI_WIDTH-1:0] hdr_byte;
    logic                cur_vld;
    logic                cur_last;
    logic                xfer;
    logic                at_max;
    logic                stall_max;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign lane[i] = req_data[i*DI_WIDTH +: DI_WIDTH];
    end

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req   (req_vld),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign hdr_byte  = HDR_BASE + DI_WIDTH'(ptr);
    assign cur_vld   = req_vld[ptr];
    assign cur_last  = req_last[ptr];
    assign xfer      = tx_din_vld && tx_rfd;
    assign at_max    = (byte_cnt == BW'(MAX_LEN - 1));
    assign stall_max = (stall_cnt == SW'(TIMEOUT - 1));
    assign busy      = (state != IDLE);

    // Byte port mux: header in HDR, granted requester passed through in DATA.
    always_comb begin
        tx_din     = '0;
        tx_din_vld = 1'b0;
        req_rdy    = '0;
        unique case (state)
            HDR: begin
                tx_din     = hdr_byte;
                tx_din_vld = 1'b1;
            end
            DATA: begin
                tx_din       = lane[ptr];
                tx_din_vld   = cur_vld;
                req_rdy[ptr] = tx_rfd;
            end
            default: begin
            end
        endcase
    end

    // Grant FSM with length cap and stall watchdog.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            gnt       <= '0;
            ptr       <= IW'(N_REQ - 1);
            byte_cnt  <= '0;
            stall_cnt <= '0;
            abort     <= 1'b0;
            trunc     <= 1'b0;
        end else begin
            abort <= 1'b0;
            trunc <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= (HDR_EN != 0) ? HDR : DATA;
                        gnt       <= pick_gnt;
                        ptr       <= pick_idx;
                        byte_cnt  <= '0;
                        stall_cnt <= '0;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        stall_cnt <= '0;
                        if (cur_last) begin
                            state <= IDLE;
                            gnt   <= '0;
                        end else if (at_max) begin
                            state <= IDLE;
                            gnt   <= '0;
                            trunc <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (!cur_vld) begin
                        if (stall_max) begin
                            state <= IDLE;
                            gnt   <= '0;
                            abort <= 1'b1;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter.
// Cycle model of the grant rules plus literal stream expectations.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int ML = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_vld = '0;
    logic [N-1:0]   req_last = '0;
    logic           tx_rfd = 1'b0;
    logic [N-1:0]   req_rdy;
    logic [W-1:0]   tx_din;
    logic           tx_din_vld;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           abort;
    logic           trunc;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ    (N),
        .DI_WIDTH (W),
        .HDR_EN   (1),
        .HDR_BASE (8'hA0),
        .MAX_LEN  (ML),
        .TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_data   (req_data),
        .req_vld    (req_vld),
        .req_last   (req_last),
        .req_rdy    (req_rdy),
        .tx_din     (tx_din),
        .tx_din_vld (tx_din_vld),
        .tx_rfd     (tx_rfd),
        .gnt        (gnt),
        .busy       (busy),
        .abort      (abort),
        .trunc      (trunc)
    );

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    // per-requester source FIFOs: {last, data}
    logic [8:0] mem [N][128];
    int wr [N] = '{default: 0};
    int rd [N] = '{default: 0};

    logic [7:0] tx_log [$];
    int         gnt_log [$];
    logic [7:0] exp_q [$];
    int n_abort = 0;
    int n_trunc = 0;

    // model state
    int m_phase = 0;
    int m_own = 0;
    int m_ptr = N - 1;
    int m_cnt = 0;
    int m_stall = 0;
    bit m_abort = 1'b0;
    bit m_trunc = 1'b0;
    bit prev_hold = 1'b0;
    logic [7:0] prev_din = '0;
    logic [N-1:0] prev_gnt = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Requester drivers: present FIFO head after each edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (rd[i] != wr[i]) begin
                req_vld[i]        = 1'b1;
                req_data[i*W +: W] = mem[i][rd[i]][7:0];
                req_last[i]       = mem[i][rd[i]][8];
            end else begin
                req_vld[i]        = 1'b0;
                req_data[i*W +: W] = '0;
                req_last[i]       = 1'b0;
            end
        end
    end

    // Compare process: check outputs, log, then advance the model.
    always @(negedge clk) begin
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_rdy;
        logic         e_vld;
        logic [7:0]   e_din;
        bit           fnd;
        int           c;
        if (run) begin
            e_gnt = '0;
            e_rdy = '0;
            e_vld = 1'b0;
            e_din = '0;
            if (m_phase != 0) e_gnt[m_own] = 1'b1;
            if (m_phase == 1) begin
                e_vld = 1'b1;
                e_din = 8'hA0 + 8'(m_own);
            end else if (m_phase == 2) begin
                e_vld = req_vld[m_own];
                e_rdy[m_own] = tx_rfd;
                e_din = mem[m_own][rd[m_own]][7:0];
            end
            chk("gnt", gnt, e_gnt);
            chk("busy", busy, m_phase != 0);
            chk("abort", abort, m_abort);
            chk("trunc", trunc, m_trunc);
            chk("tx_din_vld", tx_din_vld, e_vld);
            chk("req_rdy", req_rdy, e_rdy);
            if (e_vld || m_phase == 0) chk("tx_din", tx_din, e_din);
            if (prev_hold) begin
                chk("hold_vld", tx_din_vld, 1);
                chk("hold_din", tx_din, prev_din);
            end
            prev_hold = rst && tx_din_vld && !tx_rfd;
            prev_din = tx_din;

            if (tx_din_vld && tx_rfd) tx_log.push_back(tx_din);
            if (gnt != 0 && prev_gnt == 0) begin
                for (int i = 0; i < N; i++)
                    if (gnt[i]) gnt_log.push_back(i);
            end
            prev_gnt = gnt;
            if (abort) n_abort++;
            if (trunc) n_trunc++;

            for (int i = 0; i < N; i++)
                if (req_vld[i] && req_rdy[i]) rd[i]++;

            m_abort = 1'b0;
            m_trunc = 1'b0;
            if (!rst) begin
                m_phase = 0;
                m_ptr = N - 1;
            end else if (m_phase == 0) begin
                fnd = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    c = (m_ptr + k) % N;
                    if (!fnd && req_vld[c]) begin
                        fnd = 1'b1;
                        m_own = c;
                    end
                end
                if (fnd) begin
                    m_ptr = m_own;
                    m_phase = 1;
                    m_cnt = 0;
                    m_stall = 0;
                end
            end else if (m_phase == 1) begin
                if (tx_rfd) m_phase = 2;
            end else begin
                if (req_vld[m_own] && tx_rfd) begin
                    m_stall = 0;
                    m_cnt++;
                    if (req_last[m_own]) begin
                        m_phase = 0;
                    end else if (m_cnt == ML) begin
                        m_phase = 0;
                        m_trunc = 1'b1;
                    end
                end else if (!req_vld[m_own]) begin
                    m_stall++;
                    if (m_stall == TO) begin
                        m_phase = 0;
                        m_abort = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int r, input logic [7:0] d, input bit l);
        mem[r][wr[r]] = {l, d};
        wr[r]++;
    endtask

    task automatic clear_logs();
        tx_log.delete();
        gnt_log.delete();
        n_abort = 0;
        n_trunc = 0;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        clear_logs();
    endtask

    task automatic wait_done(input string nm, input int max, input bit bp);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < max) begin
            if (bp) tx_rfd = (n % 4 == 0) || (n % 4 == 3);
            tick();
            n++;
            done = (m_phase == 0);
            for (int i = 0; i < N; i++)
                if (rd[i] != wr[i]) done = 1'b0;
        end
        tx_rfd = 1'b1;
        chk({nm, "_done"}, done, 1);
        tick();
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_len"}, tx_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < tx_log.size())
                chk($sformatf("%s_b%0d", nm, i), tx_log[i], exp_q[i]);
        end
    endtask

    initial begin
        int start;
        int n;
        rst = 1'b0;
        tx_rfd = 1'b1;
        tick();
        run = 1'b1;
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vld", tx_din_vld, 0);
        chk("rst_din", tx_din, 0);
        chk("rst_rdy", req_rdy, 0);
        rst = 1'b1;
        clear_logs();

        // single requester
        push(0, 8'h11, 0);
        push(0, 8'h22, 0);
        push(0, 8'h33, 1);
        wait_done("single", 40, 0);
        exp_q = '{8'hA0, 8'h11, 8'h22, 8'h33};
        check_log("single");
        chk("single_gnt0", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);

        // contention
        reset_dut();
        push(0, 8'h01, 0);
        push(0, 8'h02, 1);
        push(2, 8'h05, 1);
        wait_done("cont", 60, 0);
        exp_q = '{8'hA0, 8'h01, 8'h02, 8'hA2, 8'h05};
        check_log("cont");

        // fairness
        reset_dut();
        push(0, 8'hC0, 1);
        push(0, 8'hC4, 1);
        push(1, 8'hC1, 1);
        push(2, 8'hC2, 1);
        push(3, 8'hC3, 1);
        wait_done("fair", 80, 0);
        exp_q = '{8'hA0, 8'hC0, 8'hA1, 8'hC1, 8'hA2, 8'hC2,
                  8'hA3, 8'hC3, 8'hA0, 8'hC4};
        check_log("fair");
        chk("fair_ngnt", gnt_log.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < gnt_log.size())
                chk($sformatf("fair_g%0d", i), gnt_log[i], i % 4);

        // backpressure
        reset_dut();
        push(1, 8'h31, 0);
        push(1, 8'h32, 0);
        push(1, 8'h33, 1);
        wait_done("bp", 80, 1);
        exp_q = '{8'hA1, 8'h31, 8'h32, 8'h33};
        check_log("bp");

        // length cap
        reset_dut();
        for (int i = 0; i < 6; i++) push(0, 8'h51 + 8'(i), i == 5);
        wait_done("trunc", 80, 0);
        exp_q = '{8'hA0, 8'h51, 8'h52, 8'h53, 8'h54,
                  8'hA0, 8'h55, 8'h56};
        check_log("trunc");
        chk("trunc_cnt", n_trunc, 1);
        chk("trunc_abort", n_abort, 0);

        // stall watchdog
        reset_dut();
        push(1, 8'h61, 0);
        wait_done("abort", 60, 0);
        chk("abort_cnt", n_abort, 1);
        chk("abort_busy", busy, 0);
        push(1, 8'h62, 0);
        push(1, 8'h63, 1);
        wait_done("abort2", 60, 0);
        exp_q = '{8'hA1, 8'h61, 8'hA1, 8'h62, 8'h63};
        check_log("abort");
        chk("abort_cnt2", n_abort, 1);

        // reset mid-DATA
        reset_dut();
        push(2, 8'h71, 0);
        push(2, 8'h72, 0);
        push(2, 8'h73, 0);
        push(2, 8'h74, 1);
        start = rd[2];
        n = 0;
        while (rd[2] - start < 2 && n < 30) begin
            tick();
            n++;
        end
        chk("mid_two", rd[2] - start >= 2, 1);
        rst = 1'b0;
        push(0, 8'h81, 1);
        tick();
        rst = 1'b1;
        clear_logs();
        chk("mid_gnt", gnt, 0);
        chk("mid_busy", busy, 0);
        chk("mid_vld", tx_din_vld, 0);
        chk("mid_din", tx_din, 0);
        chk("mid_rdy", req_rdy, 0);
        wait_done("mid", 60, 0);
        chk("mid_len", tx_log.size() >= 4, 1);
        if (tx_log.size() >= 4) begin
            chk("mid_b0", tx_log[0], 8'hA0);
            chk("mid_b1", tx_log[1], 8'h81);
            chk("mid_b2", tx_log[2], 8'hA2);
            chk("mid_end", tx_log[tx_log.size()-1], 8'h74);
        end
        chk("mid_g0", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
